// File: rtl/alu_ctrl_pkg.sv
// ============================================================================
// Module : alu_ctrl_pkg
// Brief  : Shared types and constants for the RV32I -> ALU control decoder.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package alu_ctrl_pkg;

    localparam logic [3:0] ALU_PASS_B = 4'h0;
    localparam logic [3:0] ALU_B_P4   = 4'h1;
    localparam logic [3:0] ALU_ADD    = 4'h2;
    localparam logic [3:0] ALU_SUB    = 4'h3;
    localparam logic [3:0] ALU_ADD_AL = 4'h4;
    localparam logic [3:0] ALU_SLL    = 4'h5;
    localparam logic [3:0] ALU_SRL    = 4'h6;
    localparam logic [3:0] ALU_SRA    = 4'h7;
    localparam logic [3:0] ALU_SLT    = 4'h8;
    localparam logic [3:0] ALU_SLTU   = 4'h9;
    localparam logic [3:0] ALU_AND    = 4'hA;
    localparam logic [3:0] ALU_OR     = 4'hB;
    localparam logic [3:0] ALU_XOR    = 4'hC;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    localparam logic [6:0] F7_ZERO = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    localparam logic [1:0] B_SEL_RS2 = 2'd0;
    localparam logic [1:0] B_SEL_IMM = 2'd1;
    localparam logic [1:0] B_SEL_PC  = 2'd2;

    typedef enum logic [2:0] {
        IMM_NONE = 3'd0,
        IMM_I    = 3'd1,
        IMM_S    = 3'd2,
        IMM_B    = 3'd3,
        IMM_U    = 3'd4,
        IMM_J    = 3'd5
    } imm_fmt_e;

    typedef enum logic [0:0] {
        ST_RUN  = 1'b0,
        ST_HALT = 1'b1
    } state_e;

    typedef struct packed {
        logic [3:0]  alu_op;
        logic        a_sel;
        logic [1:0]  b_sel;
        logic [31:0] imm;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic        rf_we;
        logic [31:0] pc;
        logic        illegal;
    } bundle_t;

    function automatic logic [31:0] gen_imm(input logic [31:0] i, input imm_fmt_e fmt);
        logic [31:0] r;
        r = '0;
        case (fmt)
            IMM_I:   r = {{20{i[31]}}, i[31:20]};
            IMM_S:   r = {{20{i[31]}}, i[31:25], i[11:7]};
            IMM_B:   r = {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
            IMM_U:   r = {i[31:12], 12'b0};
            IMM_J:   r = {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
            default: r = '0;
        endcase
        return r;
    endfunction

endpackage

`default_nettype wire

// File: rtl/alu_ctrl_comb.sv
// ============================================================================
// Module : alu_ctrl_comb
// Brief  : Purely combinational RV32I instruction -> ALU control bundle.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module alu_ctrl_comb
    import alu_ctrl_pkg::*;
(
    input  logic [31:0] instr_i,
    input  logic [31:0] pc_i,
    output bundle_t     bundle_o
);

    bundle_t     w_b;
    imm_fmt_e    w_fmt;
    logic        w_bad;
    logic        w_shamt;
    logic [2:0]  w_f3;
    logic [6:0]  w_f7;

    assign w_f3 = instr_i[14:12];
    assign w_f7 = instr_i[31:25];

    always_comb begin
        w_b       = '0;
        w_fmt     = IMM_NONE;
        w_bad     = 1'b0;
        w_shamt   = 1'b0;
        w_b.rs1   = instr_i[19:15];
        w_b.rs2   = instr_i[24:20];
        w_b.rd    = instr_i[11:7];
        case (instr_i[6:0])
            OPC_LUI: begin
                w_b.b_sel = B_SEL_IMM; w_fmt = IMM_U; w_b.rf_we = 1'b1;
            end
            OPC_AUIPC: begin
                w_b.alu_op = ALU_ADD; w_b.a_sel = 1'b1; w_b.b_sel = B_SEL_IMM;
                w_fmt = IMM_U; w_b.rf_we = 1'b1;
            end
            OPC_JAL: begin
                w_b.alu_op = ALU_B_P4; w_b.b_sel = B_SEL_PC; w_fmt = IMM_J; w_b.rf_we = 1'b1;
            end
            OPC_JALR: begin
                w_b.alu_op = ALU_B_P4; w_b.b_sel = B_SEL_PC; w_fmt = IMM_I; w_b.rf_we = 1'b1;
                w_bad = (w_f3 != 3'b000);
            end
            OPC_OP_IMM, OPC_OP: begin
                w_b.rf_we = 1'b1;
                if (instr_i[5]) w_b.b_sel = B_SEL_RS2;
                else begin
                    w_b.b_sel = B_SEL_IMM; w_fmt = IMM_I;
                end
                case (w_f3)
                    3'b000: w_b.alu_op = (instr_i[5] && w_f7 == F7_ALT) ? ALU_SUB : ALU_ADD;
                    3'b001: begin w_b.alu_op = ALU_SLL; w_shamt = 1'b1; end
                    3'b010: w_b.alu_op = ALU_SLT;
                    3'b011: w_b.alu_op = ALU_SLTU;
                    3'b100: w_b.alu_op = ALU_XOR;
                    3'b101: begin
                        w_b.alu_op = (w_f7 == F7_ALT) ? ALU_SRA : ALU_SRL; w_shamt = 1'b1;
                    end
                    3'b110: w_b.alu_op = ALU_OR;
                    default: w_b.alu_op = ALU_AND;
                endcase
                // funct7 is only meaningful for shifts (imm form) or every reg-reg op
                if (instr_i[5] || w_shamt) begin
                    if (w_f7 == F7_ALT) w_bad = !(w_f3 == 3'b101 || (instr_i[5] && w_f3 == 3'b000));
                    else                w_bad = (w_f7 != F7_ZERO);
                end
            end
            OPC_LOAD: begin
                w_b.alu_op = ALU_ADD; w_b.b_sel = B_SEL_IMM; w_fmt = IMM_I; w_b.rf_we = 1'b1;
            end
            OPC_STORE: begin
                w_b.alu_op = ALU_ADD; w_b.b_sel = B_SEL_IMM; w_fmt = IMM_S;
            end
            OPC_BRANCH: begin
                w_b.b_sel = B_SEL_RS2; w_fmt = IMM_B;
                case (w_f3[2:1])
                    2'b00:   w_b.alu_op = ALU_SUB;
                    2'b10:   w_b.alu_op = ALU_SLT;
                    2'b11:   w_b.alu_op = ALU_SLTU;
                    default: w_bad = 1'b1;
                endcase
            end
            default: w_bad = 1'b1;
        endcase

        w_b.imm = w_shamt ? {27'b0, instr_i[24:20]} : gen_imm(instr_i, w_fmt);
        if (w_bad) w_b = '0;
        w_b.illegal = w_bad;
        w_b.pc      = pc_i;
        if (!w_b.rf_we) w_b.rd = '0;
    end

    assign bundle_o = w_b;

endmodule

`default_nettype wire

// File: rtl/alu_ctrl_decode.sv
// ============================================================================
// Module : alu_ctrl_decode
// Brief  : Registered RV32I decode stage with 2-entry skid buffer.
//          Optional macro ALU_CTRL_ILLEGAL_HALT_EN halts on illegal bundles.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module alu_ctrl_decode
    import alu_ctrl_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int RF_AW = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [XLEN-1:0]  in_instr,
    input  logic [XLEN-1:0]  in_pc,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [3:0]       out_alu_op,
    output logic             out_a_sel,
    output logic [1:0]       out_b_sel,
    output logic [XLEN-1:0]  out_imm,
    output logic [RF_AW-1:0] out_rs1,
    output logic [RF_AW-1:0] out_rs2,
    output logic [RF_AW-1:0] out_rd,
    output logic             out_rf_we,
    output logic [XLEN-1:0]  out_pc,
    output logic             out_illegal,
    input  logic             illegal_clr
);

    bundle_t w_dec;
    bundle_t out_q, out_d, skid_q, skid_d;
    logic    out_valid_q, out_valid_d;
    logic    skid_valid_q, skid_valid_d;
    logic    in_ready_q, in_ready_d;
    logic    w_run, w_run_d;
    logic    w_in_acc, w_out_xfer, w_out_free;

    alu_ctrl_comb u_comb (
        .instr_i  (in_instr),
        .pc_i     (in_pc),
        .bundle_o (w_dec)
    );

`ifdef ALU_CTRL_ILLEGAL_HALT_EN
    state_e state_q, state_d;

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_RUN:  if (w_out_xfer && out_q.illegal) state_d = ST_HALT;
            ST_HALT: if (illegal_clr) state_d = ST_RUN;
            default: state_d = ST_RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) state_q <= ST_RUN;
        else       state_q <= state_d;
    end

    assign w_run   = (state_q == ST_RUN);
    assign w_run_d = (state_d == ST_RUN);
`else
    logic w_unused_clr;
    assign w_unused_clr = illegal_clr;
    assign w_run        = 1'b1;
    assign w_run_d      = 1'b1;
`endif

    assign out_valid  = out_valid_q & w_run;
    assign in_ready   = in_ready_q;
    assign w_in_acc   = in_valid & in_ready_q;
    assign w_out_xfer = out_valid & out_ready;
    assign w_out_free = !out_valid_q || w_out_xfer;

    always_comb begin
        out_d        = out_q;
        out_valid_d  = out_valid_q;
        skid_d       = skid_q;
        skid_valid_d = skid_valid_q;
        if (w_out_free) begin
            // skid holds the older entry, so it always wins the output slot
            if (skid_valid_q) begin
                out_d        = skid_q;
                out_valid_d  = 1'b1;
                skid_valid_d = 1'b0;
            end else if (w_in_acc) begin
                out_d       = w_dec;
                out_valid_d = 1'b1;
            end else begin
                out_valid_d = 1'b0;
            end
        end else if (w_in_acc) begin
            skid_d       = w_dec;
            skid_valid_d = 1'b1;
        end
        in_ready_d = !skid_valid_d && w_run_d;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            out_q        <= '0;
            out_valid_q  <= 1'b0;
            skid_q       <= '0;
            skid_valid_q <= 1'b0;
            in_ready_q   <= 1'b1;
        end else begin
            out_q        <= out_d;
            out_valid_q  <= out_valid_d;
            skid_q       <= skid_d;
            skid_valid_q <= skid_valid_d;
            in_ready_q   <= in_ready_d;
        end
    end

    assign out_alu_op  = out_q.alu_op;
    assign out_a_sel   = out_q.a_sel;
    assign out_b_sel   = out_q.b_sel;
    assign out_imm     = out_q.imm;
    assign out_rs1     = out_q.rs1;
    assign out_rs2     = out_q.rs2;
    assign out_rd      = out_q.rd;
    assign out_rf_we   = out_q.rf_we;
    assign out_pc      = out_q.pc;
    assign out_illegal = out_q.illegal;

endmodule

`default_nettype wire

// File: tb/tb_alu_ctrl_decode.sv
// ============================================================================
// Module : tb_alu_ctrl_decode
// Brief  : Directed self-checking bench for alu_ctrl_decode.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_alu_ctrl_decode;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_instr = '0;
    logic [31:0] in_pc = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [3:0]  out_alu_op;
    logic        out_a_sel;
    logic [1:0]  out_b_sel;
    logic [31:0] out_imm;
    logic [4:0]  out_rs1, out_rs2, out_rd;
    logic        out_rf_we;
    logic [31:0] out_pc;
    logic        out_illegal;
    logic        illegal_clr = 1'b0;

    int n_cmp = 0;
    int n_err = 0;

    alu_ctrl_decode #(.XLEN(32), .RF_AW(5)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_instr(in_instr), .in_pc(in_pc), .out_valid(out_valid), .out_ready(out_ready),
        .out_alu_op(out_alu_op), .out_a_sel(out_a_sel), .out_b_sel(out_b_sel),
        .out_imm(out_imm), .out_rs1(out_rs1), .out_rs2(out_rs2), .out_rd(out_rd),
        .out_rf_we(out_rf_we), .out_pc(out_pc), .out_illegal(out_illegal),
        .illegal_clr(illegal_clr)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one instruction and hold it until accepted (bounded wait).
    task automatic send(input logic [31:0] instr, input logic [31:0] pc);
        int guard;
        in_instr = instr;
        in_pc    = pc;
        in_valid = 1'b1;
        guard    = 0;
        while (!in_ready && guard < 20) begin
            tick();
            guard++;
        end
        if (!in_ready) begin
            n_cmp++; n_err++;
            $display("FAIL send_timeout: in_ready got 0 want 1");
        end
        tick();
        in_valid = 1'b0;
    endtask

    task automatic drain();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick(); tick();
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL rst_valid: got %b want 0", out_valid); end
        n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL rst_ready: got %b want 1", in_ready); end
        n_cmp++; if (out_imm !== 32'h0 || out_alu_op !== 4'h0) begin n_err++;
            $display("FAIL rst_data: got imm %h op %h want 0 0", out_imm, out_alu_op); end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_add_sub();
        send(32'h002081B3, 32'h0000_0040);
        n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL add_valid: got %b want 1", out_valid); end
        n_cmp++; if (out_alu_op !== 4'h2 || out_b_sel !== 2'd0) begin n_err++;
            $display("FAIL add_op: got op %h bsel %0d want 2 0", out_alu_op, out_b_sel); end
        n_cmp++; if (out_rs1 !== 5'd1 || out_rs2 !== 5'd2 || out_rd !== 5'd3 || out_rf_we !== 1'b1) begin n_err++;
            $display("FAIL add_regs: got %0d %0d %0d we %b want 1 2 3 1", out_rs1, out_rs2, out_rd, out_rf_we); end
        n_cmp++; if (out_pc !== 32'h40) begin n_err++; $display("FAIL add_pc: got %h want 40", out_pc); end
        drain();
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL add_drain: got %b want 0", out_valid); end
        send(32'h402081B3, 32'h0);
        n_cmp++; if (out_alu_op !== 4'h3) begin n_err++; $display("FAIL sub_op: got %h want 3", out_alu_op); end
        drain();
    endtask

    task automatic test_imm_forms();
        send(32'h40435293, 32'h0);
        n_cmp++; if (out_alu_op !== 4'h7 || out_b_sel !== 2'd1 || out_imm !== 32'd4) begin n_err++;
            $display("FAIL srai: got op %h bsel %0d imm %h want 7 1 4", out_alu_op, out_b_sel, out_imm); end
        n_cmp++; if (out_rs1 !== 5'd6 || out_rd !== 5'd5) begin n_err++;
            $display("FAIL srai_regs: got rs1 %0d rd %0d want 6 5", out_rs1, out_rd); end
        drain();
        send(32'h123450B7, 32'h0);
        n_cmp++; if (out_alu_op !== 4'h0 || out_imm !== 32'h12345000 || out_rd !== 5'd1) begin n_err++;
            $display("FAIL lui: got op %h imm %h rd %0d want 0 12345000 1", out_alu_op, out_imm, out_rd); end
        drain();
        send(32'h008000EF, 32'h0000_0100);
        n_cmp++; if (out_alu_op !== 4'h1 || out_b_sel !== 2'd2 || out_pc !== 32'h100 || out_imm !== 32'd8) begin n_err++;
            $display("FAIL jal: got op %h bsel %0d pc %h imm %h want 1 2 100 8", out_alu_op, out_b_sel, out_pc, out_imm); end
        drain();
    endtask

    task automatic test_branch();
        send(32'h00209463, 32'h0);
        n_cmp++; if (out_alu_op !== 4'h3 || out_imm !== 32'd8 || out_rf_we !== 1'b0 || out_rd !== 5'd0) begin n_err++;
            $display("FAIL bne: got op %h imm %h we %b rd %0d want 3 8 0 0", out_alu_op, out_imm, out_rf_we, out_rd); end
        drain();
        send(32'h0020A463, 32'h0);
        n_cmp++; if (out_illegal !== 1'b1 || out_alu_op !== 4'h0) begin n_err++;
            $display("FAIL br_f3_01x: got ill %b op %h want 1 0", out_illegal, out_alu_op); end
        drain();
`ifdef ALU_CTRL_ILLEGAL_HALT_EN
        illegal_clr = 1'b1; tick(); illegal_clr = 1'b0; tick();
`endif
    endtask

    task automatic test_illegal();
        send(32'hFFFFFFFF, 32'h0);
        n_cmp++; if (out_illegal !== 1'b1 || out_rf_we !== 1'b0 || out_alu_op !== 4'h0 || out_imm !== 32'h0) begin n_err++;
            $display("FAIL illegal: got ill %b we %b op %h imm %h want 1 0 0 0", out_illegal, out_rf_we, out_alu_op, out_imm); end
        drain();
`ifdef ALU_CTRL_ILLEGAL_HALT_EN
        tick(); tick();
        n_cmp++; if (in_ready !== 1'b0 || out_valid !== 1'b0) begin n_err++;
            $display("FAIL halt: got rdy %b vld %b want 0 0", in_ready, out_valid); end
        illegal_clr = 1'b1; tick(); illegal_clr = 1'b0;
        n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL halt_clr: got rdy %b want 1", in_ready); end
`else
        n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL illegal_flow: got rdy %b want 1", in_ready); end
`endif
        send(32'h002081B3, 32'h0);
        n_cmp++; if (out_valid !== 1'b1 || out_alu_op !== 4'h2) begin n_err++;
            $display("FAIL resume: got vld %b op %h want 1 2", out_valid, out_alu_op); end
        drain();
    endtask

    task automatic test_back_to_back();
        logic [4:0] rx_rd [4];
        logic [31:0] rx_imm [4];
        int sent = 0, rcvd = 0, acc_at_drop = -1;
        bit acc, xfer;
        for (int c = 0; c < 40 && rcvd < 4; c++) begin
            out_ready = (c >= 3);
            in_valid  = (sent < 4);
            in_instr  = ((sent + 1) << 20) | ((10 + sent) << 7) | 32'h13;
            #0;
            if (!in_ready && acc_at_drop < 0) acc_at_drop = sent;
            if (c == 2) begin
                n_cmp++; if (out_rd !== 5'd10 || out_valid !== 1'b1) begin n_err++;
                    $display("FAIL b2b_stall: got rd %0d vld %b want 10 1", out_rd, out_valid); end
            end
            acc  = in_valid && in_ready;
            xfer = out_valid && out_ready;
            if (xfer) begin rx_rd[rcvd] = out_rd; rx_imm[rcvd] = out_imm; rcvd++; end
            tick();
            if (acc) sent++;
        end
        in_valid = 1'b0; out_ready = 1'b0;
        n_cmp++; if (acc_at_drop !== 2) begin n_err++; $display("FAIL b2b_drop: got %0d want 2", acc_at_drop); end
        n_cmp++; if (rcvd !== 4) begin n_err++; $display("FAIL b2b_count: got %0d want 4", rcvd); end
        for (int k = 0; k < rcvd; k++) begin
            n_cmp++;
            if (rx_rd[k] !== 5'(10 + k) || rx_imm[k] !== 32'(k + 1)) begin n_err++;
                $display("FAIL b2b_order%0d: got rd %0d imm %h want %0d %h", k, rx_rd[k], rx_imm[k], 10 + k, k + 1); end
        end
        tick();
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL b2b_empty: got %b want 0", out_valid); end
    endtask

    task automatic test_reset_mid();
        send(32'h00100513, 32'h10);
        send(32'h00200593, 32'h14);
        n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL mid_full: got rdy %b want 0", in_ready); end
        reset = 1'b1; tick(); reset = 1'b0;
        n_cmp++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin n_err++;
            $display("FAIL mid_rst: got vld %b rdy %b want 0 1", out_valid, in_ready); end
        n_cmp++; if (out_imm !== 32'h0 || out_rd !== 5'd0 || out_pc !== 32'h0) begin n_err++;
            $display("FAIL mid_data: got imm %h rd %0d pc %h want 0 0 0", out_imm, out_rd, out_pc); end
        out_ready = 1'b1; tick(); tick(); out_ready = 1'b0;
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL mid_flush: got %b want 0", out_valid); end
    endtask

    initial begin
        test_reset();
        test_add_sub();
        test_imm_forms();
        test_branch();
        test_illegal();
        test_back_to_back();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/alu_ctrl_decode.md
Name: alu_ctrl_decode

Overview:
Registered decode stage that turns RV32I instruction words into control for the team's 4-bit-opcode ALU (opcode, operand selects, immediate).
- Sits between fetch and execute; it is the initiator/producer side of the ALU op interface.
- Uses a valid/ready handshake on both sides.
- Holds results in a 2-entry skid buffer so full throughput survives backpressure.

Parameters:
XLEN, 32, datapath width of instr/pc/imm; only 32 supported.
RF_AW, 5, register-file index width.

Ports:
clk  in  1  rising-edge clock.
reset  in  1  synchronous, active-high reset.
in_valid  in  1  instr/pc valid.
in_ready  out  1  stage can accept.
in_instr  in  32  instruction word.
in_pc  in  32  instruction address.
out_valid  out  1  decoded bundle valid.
out_ready  in  1  execute accepts.
out_alu_op  out  4  ALU opcode.
out_a_sel  out  1  0=rs1, 1=pc.
out_b_sel  out  2  0=rs2, 1=imm, 2=pc, 3=reserved.
out_imm  out  32  sign-extended immediate.
out_rs1, out_rs2, out_rd  out  5 each  register indices.
out_rf_we  out  1  write-back enable.
out_pc  out  32  pc passthrough.
out_illegal  out  1  bundle is an illegal instruction.
illegal_clr  in  1  resume after illegal (used only with ILLEGAL_HALT_EN).

Behaviour:
- Clock and reset: single clock domain, clk. Reset is synchronous and active-high on reset.
- Reset values: out_valid=0, in_ready=1, skid empty, all out_* data=0, state=RUN.
- ALU opcodes: 0 pass B, 1 B+4, 2 ADD, 3 SUB, 4 (A+B)&~1, 5 SLL, 6 SRL, 7 SRA, 8 SLT, 9 SLTU, A AND, B OR, C XOR. D-F are never emitted.
- Decode by opcode[6:0]:
  - LUI 0110111: op0, b=imm U, we=1.
  - AUIPC 0010111: op2, a=pc, b=imm U, we=1.
  - JAL 1101111: op1, b=pc, imm=J, we=1.
  - JALR 1100111 with f3=000: op1, b=pc, imm=I, we=1.
  - OP-IMM 0010011:
    - f3 000 -> 2, 010 -> 8, 011 -> 9, 100 -> C, 110 -> B, 111 -> A; b=imm I.
    - f3 001 with f7=0000000 -> 5.
    - f3 101 with f7=0000000 -> 6; with f7=0100000 -> 7.
    - Shift immediate is the zero-extended shamt in [4:0].
  - OP 0110011: same f3 map, b=rs2; f3=000 with f7=0100000 -> 3. Any other f7 is illegal.
  - LOAD 0000011: op2, b=imm I, we=1.
  - STORE 0100011: op2, b=imm S, we=0.
  - BRANCH 1100011: f3 00x -> 3, 10x -> 8, 11x -> 9; b=rs2, imm=B, we=0. f3 01x is illegal.
  - Anything else: illegal=1, op0, we=0, selects 0, imm 0.
- rd is forced to 0 when we=0. A write to rd=0 keeps we=1; the register file ignores it.
- Latency: an accepted input appears on out_* the next cycle. Outputs are registered, with no combinational in->out path.
- Handshake:
  - Transfer occurs when valid&ready on the same edge.
  - out_* is stable while out_valid=1 and out_ready=0.
  - in_ready is registered and equals "skid empty".
- Skid buffer:
  - If out is stalled and an input is accepted, the input goes to skid and in_ready drops next cycle.
  - Skid drains to out on the next out transfer.
  - Order is strictly preserved.
- Simultaneous events:
  - Out transfer plus in accept with skid empty: out reloads directly.
  - Out transfer with skid full: out takes skid, and in_ready rises next cycle.
- Reset mid-stream discards both entries.

Optional Feature:
ALU_CTRL_ILLEGAL_HALT_EN
- With the macro: two-state FSM, RUN and HALT.
  - When an illegal bundle transfers on out, go to HALT.
  - In HALT: in_ready=0 and out_valid=0.
  - illegal_clr=1 returns to RUN next cycle. Any queued skid entry is then presented.
  - illegal_clr in RUN has no effect.
- Without the macro: illegal bundles flow as NOPs tagged out_illegal=1, and illegal_clr is ignored.

Decomposition:
- Package alu_ctrl_pkg holds:
  - The ALU opcode localparams (ALU_PASS_B .. ALU_XOR).
  - The RV32 opcode constants.
  - B_SEL_* encodings.
  - A packed decoded-bundle struct.
  - The immediate-format enum (I/S/B/U/J).
- One sub-module, alu_ctrl_comb: a purely combinational instr -> bundle function.
- The top holds the skid buffer and the FSM.

Test Plan:
- 0x002081B3 (ADD x3,x1,x2) -> op=2, b_sel=0, rs1=1, rs2=2, rd=3, we=1, out_valid one cycle after accept.
- 0x402081B3 -> op=3. 0x40435293 (SRAI x5,x6,4) -> op=7, b_sel=1, imm=4.
- 0x123450B7 (LUI x1,0x12345) -> op=0, imm=0x12345000. JAL pc=0x100 -> op=1, b_sel=2, out_pc=0x100.
- Backpressure: stream 4 back-to-back instrs with out_ready held 0 for 3 cycles.
  - in_ready drops after the 2nd accept.
  - All 4 emerge in order, with no drop or duplicate.
- 0xFFFFFFFF:
  - Without the macro: out_illegal=1, we=0, op=0.
  - With the macro: after transfer, in_ready=0 until an illegal_clr pulse, then resume.
- Reset asserted with both entries full -> next cycle out_valid=0, in_ready=1, out data=0.
